wisc_mem_ctrl: RTL and testbench
================================

# wisc_mem_ctrl

Memory-stage access controller for the WISC 5-stage pipeline. Consumes the execute stage's outputs (ALU result as address, store data, read/write enables, halt) from the EX/MEM pipeline register. Runs the request/stall/done handshake with the multicycle data memory. Returns load data to writeback and stalls the pipeline until each access completes.

## Interface
Parameters:
- TIMEOUT, 16, max WAIT cycles before a missing `mem_done` is declared an error (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_result  in  16  access address from EX/MEM register
- write_data  in  16  store data from EX/MEM register
- mem_write_enable  in  1  store request
- mem_read_enable  in  1  load request
- halt_in  in  1  HALT instruction in MEM stage
- mem_data_in  in  16  read data from memory, valid with `mem_done`
- mem_done  in  1  memory completed the outstanding access
- mem_stall  in  1  memory cannot accept a request this cycle
- mem_err  in  1  memory error, sampled with `mem_done`
- mem_addr  out  16  address to memory
- mem_wdata  out  16  store data to memory
- mem_rd  out  1  read request strobe
- mem_wr  out  1  write request strobe
- mem_createdump  out  1  one-cycle memory dump strobe on halt
- read_data  out  16  registered load data to WB
- stall_pipe  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- halt_out  out  1  processor halted
- err  out  1  sticky error flag

## Operation
- FSM states: IDLE, WAIT, DONE, HALT, ERR.
- `mem_addr` = `alu_result` and `mem_wdata` = `write_data` at all times (combinational pass-through).
- `access` = (`mem_read_enable` | `mem_write_enable`). `bad` = (`mem_read_enable` & `mem_write_enable`) | (`access` & `alu_result[0]`).

IDLE:
- `bad` → ERR with no request.
- `access` and not `bad`:
  - Drive `mem_rd` = `mem_read_enable` and `mem_wr` = `mem_write_enable`; `stall_pipe` = 1.
  - If `mem_stall`, remain in IDLE and re-drive the request next cycle.
  - Otherwise the request is accepted. If `mem_done` is also high, capture (load) and go to DONE. Otherwise go to WAIT and clear the counter.
- `halt_in` with no access → pulse `mem_createdump` for this cycle, go to HALT.
- Otherwise: no strobes, `stall_pipe` = 0.

WAIT:
- `mem_rd` = `mem_wr` = 0; `stall_pipe` = 1; counter increments.
- `mem_done` & `mem_err` → ERR.
- `mem_done` → capture `mem_data_in` into `read_data` (loads only; stores leave `read_data` unchanged) → DONE.
- Counter reaches TIMEOUT−1 without `mem_done` → ERR.

DONE:
- `stall_pipe` = 0 and no strobes; the pipeline advances at the end of this cycle. Next state is IDLE.
- This state guarantees the same EX/MEM contents are never issued twice.

HALT:
- Terminal. `halt_out` = 1, `stall_pipe` = 0, no strobes, `mem_createdump` = 0 after the first cycle.

ERR:
- Terminal. `err` = 1, `stall_pipe` = 1, no strobes.

Other rules:
- `mem_done` seen in IDLE, DONE, HALT or ERR is ignored; this covers stale responses after reset.
- Reset mid-operation (any state) → IDLE. Counter cleared, outstanding access abandoned.

## Timing
- Reset values: state IDLE, `read_data` = 0x0000, `err` = 0, `halt_out` = 0, `mem_rd` = `mem_wr` = `mem_createdump` = 0, `stall_pipe` = 0. Strobes are forced low while `rst` is high.
- Minimum access cost is 1 stall cycle (accept+done in the IDLE cycle) plus the DONE cycle.
- Memory latency N ≥ 1 cycles after acceptance costs N+1 stall cycles, then DONE.
- `read_data` is valid from the DONE cycle until the next load capture.
- Each `mem_stall` cycle adds one stall cycle; the request is held stable throughout.
- The WAIT counter is $clog2(TIMEOUT) bits wide and never wraps. Timeout is detected on the cycle the counter equals TIMEOUT−1.
- `mem_createdump` is high for exactly one cycle, coincident with the IDLE→HALT transition.

## Test plan
- Load addr 0x0010, memory returns 0xBEEF 2 cycles after accept → `mem_rd` high 1 cycle, `stall_pipe` high 3 cycles, DONE with `read_data` = 0xBEEF, then IDLE.
- Store 0x1234 to 0x0020 with `mem_stall` high 2 cycles, `mem_done` same cycle as accept → `mem_wr` high 3 cycles, `mem_wdata` = 0x1234 stable, `read_data` unchanged.
- Load with `mem_done` never asserted, TIMEOUT = 16 → ERR after 16 WAIT cycles, `err` = 1 and `stall_pipe` = 1 until reset.
- Load at 0x0011, and separately rd & wr both high → immediate ERR, no `mem_rd`/`mem_wr` strobe ever driven.
- `rst` asserted in WAIT, then `mem_done` arrives → IDLE, `read_data` = 0x0000, the late done is ignored, and the next load completes normally.
- `halt_in` with no access → `mem_createdump` for 1 cycle, `halt_out` = 1 thereafter, no further strobes.

Source files
------------

// File: rtl/wisc_mem_ctrl.sv
// WISC memory-stage controller: issues loads/stores to a multicycle data memory,
// stalls the pipeline until each access completes and captures load data for WB.
module wisc_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] alu_result,
  input  logic [15:0] write_data,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  input  logic        halt_in,
  input  logic [15:0] mem_data_in,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_createdump,
  output logic [15:0] read_data,
  output logic        stall_pipe,
  output logic        halt_out,
  output logic        err,
  output logic [2:0]  fsm_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] DONE = 3'd2;
  localparam logic [2:0] HALT = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [CW-1:0] cnt;
  logic          is_load;
  logic          access;
  logic          bad;
  logic          issue;
  logic          capture;

  assign mem_addr  = alu_result;
  assign mem_wdata = write_data;
  assign fsm_state = state;

  assign access = mem_read_enable | mem_write_enable;
  assign bad    = (mem_read_enable & mem_write_enable) | (access & alu_result[0]);
  assign issue  = (state == IDLE) & access & ~bad;

  // Load data is captured on the completing edge; stores never touch read_data.
  assign capture = mem_done & ~mem_err &
                   (((state == IDLE) & issue & ~mem_stall & mem_read_enable) |
                    ((state == WAIT) & is_load));

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (bad)
          nxt = ERR;
        else if (access) begin
          if (!mem_stall)
            nxt = mem_done ? (mem_err ? ERR : DONE) : WAIT;
        end else if (halt_in)
          nxt = HALT;
      end
      WAIT: begin
        if (mem_done)
          nxt = mem_err ? ERR : DONE;
        else if (cnt == LAST)
          nxt = ERR;
      end
      DONE:    nxt = IDLE;
      HALT:    nxt = HALT;
      ERR:     nxt = ERR;
      default: nxt = IDLE;
    endcase
  end

  // A faulted access keeps the pipeline frozen in the cycle it is detected.
  assign mem_rd         = ~rst & issue & mem_read_enable;
  assign mem_wr         = ~rst & issue & mem_write_enable;
  assign mem_createdump = ~rst & (state == IDLE) & ~access & halt_in;
  assign stall_pipe     = ~rst & (((state == IDLE) & access) | (state == WAIT) | (state == ERR));
  assign err            = (state == ERR);
  assign halt_out       = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_load   <= 1'b0;
      read_data <= 16'h0000;
    end else begin
      state <= nxt;
      if (state == IDLE) begin
        cnt     <= '0;
        is_load <= mem_read_enable;
      end else if ((state == WAIT) && (cnt != LAST)) begin
        cnt <= cnt + 1'b1;
      end
      if (capture)
        read_data <= mem_data_in;
    end
  end

endmodule

// File: tb/tb_wisc_mem_ctrl.sv
// Cycle-by-cycle vector bench for wisc_mem_ctrl: each record gives the inputs for
// one cycle and the outputs expected in that cycle.
module tb_wisc_mem_ctrl;

  typedef struct {
    logic        rst, re, we, hl;
    logic [15:0] addr, wd, md;
    logic        dn, st, me;
    logic        e_rd, e_wr, e_dump, e_stall, e_err, e_halt;
    logic [15:0] e_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] alu_result, write_data, mem_data_in;
  logic        mem_write_enable, mem_read_enable, halt_in;
  logic        mem_done, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, read_data;
  logic        mem_rd, mem_wr, mem_createdump, stall_pipe, halt_out, err;
  logic [2:0]  fsm_state;

  vec_t        vecs[$];
  logic [53:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  wisc_mem_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .write_data(write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .halt_in(halt_in), .mem_data_in(mem_data_in), .mem_done(mem_done),
    .mem_stall(mem_stall), .mem_err(mem_err), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_createdump(mem_createdump), .read_data(read_data),
    .stall_pipe(stall_pipe), .halt_out(halt_out), .err(err), .fsm_state(fsm_state)
  );

  task automatic add(input logic r, re, we, hl, input logic [15:0] a, wd, md,
                     input logic dn, st, me, input logic e_rd, e_wr, e_dump,
                     input logic e_stall, e_err, e_halt, input logic [15:0] e_rdata);
    vec_t v;
    v.rst = r; v.re = re; v.we = we; v.hl = hl; v.addr = a; v.wd = wd; v.md = md;
    v.dn = dn; v.st = st; v.me = me; v.e_rd = e_rd; v.e_wr = e_wr; v.e_dump = e_dump;
    v.e_stall = e_stall; v.e_err = e_err; v.e_halt = e_halt; v.e_rdata = e_rdata;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, push the expectation, compare just before the rising edge.
  task automatic apply(input vec_t v, input int idx);
    logic [53:0] exp_v, act_v;
    @(negedge clk);
    rst = v.rst; mem_read_enable = v.re; mem_write_enable = v.we; halt_in = v.hl;
    alu_result = v.addr; write_data = v.wd; mem_data_in = v.md;
    mem_done = v.dn; mem_stall = v.st; mem_err = v.me;
    exp_q.push_back({v.e_rd, v.e_wr, v.e_dump, v.e_stall, v.e_err, v.e_halt,
                     v.e_rdata, v.addr, v.wd});
    #4;
    act_v = {mem_rd, mem_wr, mem_createdump, stall_pipe, err, halt_out,
             read_data, mem_addr, mem_wdata};
    exp_v = exp_q.pop_front();
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL vec%0d rd/wr/dump/stall/err/halt/rdata/addr/wdata got %b %b %b %b %b %b %h %h %h want %b %b %b %b %b %b %h %h %h",
               idx, act_v[53], act_v[52], act_v[51], act_v[50], act_v[49], act_v[48],
               act_v[47:32], act_v[31:16], act_v[15:0],
               exp_v[53], exp_v[52], exp_v[51], exp_v[50], exp_v[49], exp_v[48],
               exp_v[47:32], exp_v[31:16], exp_v[15:0]);
    end
  endtask

  initial begin
    rst = 1'b1; mem_read_enable = 0; mem_write_enable = 0; halt_in = 0;
    alu_result = 0; write_data = 0; mem_data_in = 0;
    mem_done = 0; mem_stall = 0; mem_err = 0;
    repeat (2) @(posedge clk);

    //  rst re we hl addr      wd        md        dn st me  rd wr dp stl er ht rdata
    // Reset holds strobes low even with a request present.
    add(1, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0000);
    // Load 0x0010, data returns two cycles after accept.
    add(0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0, 0,  0, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'hBEEF);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'hBEEF);
    // Store 0x1234 to 0x0020, memory stalls two cycles, done with accept.
    add(0, 0, 1, 0, 16'h0020, 16'h1234, 16'h0000, 0, 1, 0,  0, 1, 0, 1, 0, 0, 16'hBEEF);
    add(0, 0, 1, 0, 16'h0020, 16'h1234, 16'h0000, 0, 1, 0,  0, 1, 0, 1, 0, 0, 16'hBEEF);
    add(0, 0, 1, 0, 16'h0020, 16'h1234, 16'hAAAA, 1, 0, 0,  0, 1, 0, 1, 0, 0, 16'hBEEF);
    add(0, 0, 1, 0, 16'h0020, 16'h1234, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'hBEEF);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'hBEEF);
    // Reset while waiting; the late done afterwards is ignored.
    add(0, 1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'hBEEF);
    add(0, 1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 0, 0, 16'hBEEF);
    add(1, 1, 0, 0, 16'h0030, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'hBEEF);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'h0000);
    // Next load completes in the accept cycle.
    add(0, 1, 0, 0, 16'h0040, 16'h0000, 16'h5A5A, 1, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'h5A5A);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 0, 16'h5A5A);
    // Memory error reported with done.
    add(0, 1, 0, 0, 16'h0070, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h5A5A);
    add(0, 1, 0, 0, 16'h0070, 16'h0000, 16'h1111, 1, 0, 1,  0, 0, 0, 1, 0, 0, 16'h5A5A);
    add(0, 1, 0, 0, 16'h0070, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 1, 0, 16'h5A5A);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 1, 0, 16'h5A5A);
    // Odd address: immediate error, no strobe, later done ignored.
    add(0, 1, 0, 0, 16'h0011, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 0, 0, 16'h0011, 16'h0000, 16'hFFFF, 1, 0, 0,  0, 0, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 1, 0, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 1, 0, 16'h0000);
    // Read and write together: immediate error.
    add(0, 1, 1, 0, 16'h0050, 16'h4321, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 0, 0, 16'h0000);
    add(0, 1, 1, 0, 16'h0050, 16'h4321, 16'h0000, 0, 0, 0,  0, 0, 0, 1, 1, 0, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 1, 0, 16'h0000);
    // Timeout: accept, 16 WAIT cycles with no done, then sticky error.
    add(0, 1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 0, 0, 0,  1, 0, 0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 16; i++)
      add(0, 1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0000);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0, 0, 16'h0060, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 16'h0000);
    add(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 1, 0, 16'h0000);
    // Halt: one dump pulse, then terminal with no strobes.
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 1, 0, 0, 0, 16'h0000);
    add(0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 1, 16'h0000);
    add(0, 1, 0, 0, 16'h0080, 16'h0000, 16'h7777, 1, 0, 0,  0, 0, 0, 0, 0, 1, 16'h0000);
    add(0, 0, 1, 1, 16'h0082, 16'h9999, 16'h0000, 0, 0, 0,  0, 0, 0, 0, 0, 1, 16'h0000);

    foreach (vecs[i]) apply(vecs[i], i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
